// File: rtl/spi_pmod_pkg.sv
// spi_pmod_pkg: shared constants for the SPI PMOD master (state encoding, default word width).
// No ports; imported by the interface, the top level and the bench.
package spi_pmod_pkg;
    localparam int DATA_W_DEF = 8;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        SHIFT = ST_SHIFT,
        HOLD  = ST_HOLD
    } state_t;
endpackage

// File: rtl/spi_pmod_master_if.sv
// spi_pmod_master_if: user handshake plus SPI pins of the PMOD master.
// Ports (master view): in start, tx_data[DATA_W], miso; out busy, done, rx_data[DATA_W], sclk, mosi, cs_n.
// The slave modport is the mirror image, used by whatever drives the user side and the SPI device.
interface spi_pmod_master_if import spi_pmod_pkg::*; #(parameter int DATA_W = DATA_W_DEF);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic              cs_n;
    modport master (input start, tx_data, miso, output busy, done, rx_data, sclk, mosi, cs_n);
    modport slave  (output start, tx_data, miso, input busy, done, rx_data, sclk, mosi, cs_n);
endinterface

// File: rtl/tick_edge.sv
// tick_edge: one-cycle pulse on each rising edge of a slow level sampled in the fast clock domain.
// Ports: clk_100MHz (clock), rst_n (async active-low reset), level_in (slow level), tick_out (pulse).
module tick_edge (
    input  logic clk_100MHz,
    input  logic rst_n,
    input  logic level_in,
    output logic tick_out
);
    logic level_q;
    always_ff @(posedge clk_100MHz or negedge rst_n)
        if (!rst_n) level_q <= 1'b0;
        else        level_q <= level_in;
    assign tick_out = level_in & ~level_q;
endmodule

// File: rtl/spi_pmod_master.sv
// spi_pmod_master: SPI mode-0 master, one DATA_W-bit word per start, timed by ticks from a 200 kHz level.
// Ports: clk_100MHz (clock), rst_n (async active-low reset), clk_200KHz (divided level, sampled as data),
//        bus (spi_pmod_master_if.master: start/tx_data in, busy/done/rx_data out, sclk/mosi/cs_n out, miso in).
module spi_pmod_master import spi_pmod_pkg::*; #(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int CS_SETUP_TICKS = 1,
    parameter int CS_HOLD_TICKS  = 1
) (
    input  logic clk_100MHz,
    input  logic rst_n,
    input  logic clk_200KHz,
    spi_pmod_master_if.master bus
);
    localparam int BW   = $clog2(DATA_W + 1);
    localparam int MAXT = (CS_SETUP_TICKS > CS_HOLD_TICKS) ? CS_SETUP_TICKS : CS_HOLD_TICKS;
    localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;

    state_t            state, state_n;
    logic              tick;
    logic              sclk_q, sclk_n;
    logic              mosi_q, mosi_n;
    logic              cs_q, cs_n_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic [DATA_W-1:0] rx_q, rx_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic [BW-1:0]     bcnt, bcnt_n;
    logic [TW-1:0]     tcnt, tcnt_n;

    tick_edge u_tick (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .level_in   (clk_200KHz),
        .tick_out   (tick)
    );

    always_ff @(posedge clk_100MHz or negedge rst_n)
        if (!rst_n) begin
            state  <= IDLE;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            cs_q   <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rx_q   <= '0;
            sh     <= '0;
            bcnt   <= '0;
            tcnt   <= '0;
        end else begin
            state  <= state_n;
            sclk_q <= sclk_n;
            mosi_q <= mosi_n;
            cs_q   <= cs_n_n;
            busy_q <= busy_n;
            done_q <= done_n;
            rx_q   <= rx_n;
            sh     <= sh_n;
            bcnt   <= bcnt_n;
            tcnt   <= tcnt_n;
        end

    // Only IDLE looks at start, so requests during a transfer fall away and a
    // start in the done cycle (already back in IDLE) is taken immediately.
    always_comb begin
        state_n = state;
        sclk_n  = sclk_q;
        mosi_n  = mosi_q;
        cs_n_n  = cs_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        rx_n    = rx_q;
        sh_n    = sh;
        bcnt_n  = bcnt;
        tcnt_n  = tcnt;
        case (state)
            IDLE:
                if (bus.start) begin
                    sh_n    = bus.tx_data;
                    mosi_n  = bus.tx_data[DATA_W-1];
                    cs_n_n  = 1'b0;
                    busy_n  = 1'b1;
                    bcnt_n  = '0;
                    tcnt_n  = '0;
                    state_n = SETUP;
                end
            SETUP:
                if (tick) begin
                    if (tcnt == TW'(CS_SETUP_TICKS - 1)) begin
                        sclk_n  = 1'b0;
                        state_n = SHIFT;
                    end else tcnt_n = tcnt + 1'b1;
                end
            SHIFT:
                if (tick) begin
                    if (!sclk_q) begin
                        // Rising edge: shift left, received bit enters at the LSB.
                        sclk_n = 1'b1;
                        sh_n   = {sh[DATA_W-2:0], bus.miso};
                        bcnt_n = bcnt + 1'b1;
                    end else begin
                        // Falling edge: the next bit to send is now at the MSB.
                        sclk_n = 1'b0;
                        if (bcnt == BW'(DATA_W)) begin
                            mosi_n  = 1'b0;
                            tcnt_n  = '0;
                            state_n = HOLD;
                        end else mosi_n = sh[DATA_W-1];
                    end
                end
            HOLD:
                if (tick) begin
                    if (tcnt == TW'(CS_HOLD_TICKS - 1)) begin
                        cs_n_n  = 1'b1;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        rx_n    = sh;
                        state_n = IDLE;
                    end else tcnt_n = tcnt + 1'b1;
                end
            default: state_n = IDLE;
        endcase
    end

    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.cs_n    = cs_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_q;
endmodule

// File: tb/tb_spi_pmod_master.sv
// tb_spi_pmod_master: directed self-checking bench for spi_pmod_master (loopback, stuck-high miso,
// ignored restart, back-to-back, async reset abort, stalled tick source).
module tb_spi_pmod_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic c200 = 1'b0;
    logic div_en = 1'b1;
    logic loop = 1'b1;
    logic miso_val = 1'b0;
    int   dcnt = 0;

    int passed = 0;
    int total = 0;

    int done_cnt = 0, rise_cnt = 0, hi_run = 0, last_hi = 0, lo_run = 0, last_cs = 0;
    logic sclk_p = 1'b0;
    logic [31:0] mbits = '0;
    int d0, r0;

    spi_pmod_master_if #(.DATA_W(8)) bus ();

    spi_pmod_master #(.DATA_W(8), .CS_SETUP_TICKS(1), .CS_HOLD_TICKS(1)) dut (
        .clk_100MHz (clk),
        .rst_n      (rst_n),
        .clk_200KHz (c200),
        .bus        (bus)
    );

    assign bus.miso = loop ? bus.mosi : miso_val;

    always #5 clk = ~clk;

    // 200 kHz level: toggles every 250 fast cycles while enabled.
    always @(posedge clk)
        if (div_en) begin
            if (dcnt == 249) begin
                dcnt <= 0;
                c200 <= ~c200;
            end else dcnt <= dcnt + 1;
        end

    always @(negedge clk) begin
        sclk_p <= bus.sclk;
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.sclk && !sclk_p) begin
            rise_cnt <= rise_cnt + 1;
            mbits    <= {mbits[30:0], bus.mosi};
        end
        if (bus.sclk) hi_run <= hi_run + 1;
        else if (hi_run != 0) begin
            last_hi <= hi_run;
            hi_run  <= 0;
        end
        if (!bus.cs_n) lo_run <= lo_run + 1;
        else if (lo_run != 0) begin
            last_cs <= lo_run;
            lo_run  <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] d);
        bus.tx_data = d;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < budget);
        check(tag, 32'(bus.done), 32'd1);
    endtask

    task automatic snap();
        d0 = done_cnt;
        r0 = rise_cnt;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.tx_data = '0;
        repeat (3) @(negedge clk);
        check("rst_sclk", 32'(bus.sclk), 32'd0);
        check("rst_mosi", 32'(bus.mosi), 32'd0);
        check("rst_cs_n", 32'(bus.cs_n), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rx", 32'(bus.rx_data), 32'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // loopback 0xA5
        snap();
        send(8'hA5);
        check("a5_busy", 32'(bus.busy), 32'd1);
        check("a5_cs_low", 32'(bus.cs_n), 32'd0);
        check("a5_mosi_msb", 32'(bus.mosi), 32'd1);
        wait_done("a5_done", 12000);
        repeat (3) @(negedge clk);
        check("a5_rx", 32'(bus.rx_data), 32'hA5);
        check("a5_mosi_bits", 32'(mbits[7:0]), 32'hA5);
        check("a5_rises", 32'(rise_cnt - r0), 32'd8);
        check("a5_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("a5_idle_busy", 32'(bus.busy), 32'd0);
        check("a5_idle_cs", 32'(bus.cs_n), 32'd1);

        // miso stuck high, 0x3C
        loop = 1'b0;
        miso_val = 1'b1;
        snap();
        send(8'h3C);
        wait_done("3c_done", 12000);
        repeat (3) @(negedge clk);
        check("3c_rx", 32'(bus.rx_data), 32'hFF);
        check("3c_sclk_high", 32'(last_hi), 32'd500);
        check("3c_cs_window", 32'(last_cs >= 8500 && last_cs <= 9500), 32'd1);
        check("3c_rises", 32'(rise_cnt - r0), 32'd8);
        loop = 1'b1;

        // start re-pulsed mid-transfer is ignored
        snap();
        send(8'h96);
        repeat (3000) @(negedge clk);
        send(8'h00);
        check("mid_busy", 32'(bus.busy), 32'd1);
        wait_done("mid_done", 12000);
        repeat (20) @(negedge clk);
        check("mid_rx", 32'(bus.rx_data), 32'h96);
        check("mid_mosi_bits", 32'(mbits[7:0]), 32'h96);
        check("mid_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("mid_idle", 32'(bus.busy), 32'd0);

        // back-to-back: start in the done cycle
        snap();
        send(8'h24);
        wait_done("b2b_done1", 12000);
        check("b2b_rx1", 32'(bus.rx_data), 32'h24);
        check("b2b_cs_gap", 32'(bus.cs_n), 32'd1);
        send(8'h81);
        check("b2b_cs_low", 32'(bus.cs_n), 32'd0);
        check("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done("b2b_done2", 12000);
        repeat (3) @(negedge clk);
        check("b2b_rx2", 32'(bus.rx_data), 32'h81);
        check("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);
        check("b2b_rises", 32'(rise_cnt - r0), 32'd16);

        // async reset during bit 4
        snap();
        send(8'hF0);
        for (int n = 0; n < 8000 && (rise_cnt - r0) < 4; n++) @(negedge clk);
        check("rst_bit4_reached", 32'(rise_cnt - r0), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sclk", 32'(bus.sclk), 32'd0);
        check("arst_cs_n", 32'(bus.cs_n), 32'd1);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_rx", 32'(bus.rx_data), 32'h00);
        repeat (600) @(negedge clk);
        rst_n = 1'b1;
        repeat (600) @(negedge clk);
        check("arst_no_done", 32'(done_cnt - d0), 32'd0);
        snap();
        send(8'h5A);
        wait_done("post_rst_done", 12000);
        repeat (3) @(negedge clk);
        check("post_rst_rx", 32'(bus.rx_data), 32'h5A);
        check("post_rst_bits", 32'(mbits[7:0]), 32'h5A);
        check("post_rst_done_cnt", 32'(done_cnt - d0), 32'd1);

        // tick source frozen
        div_en = 1'b0;
        @(negedge clk);
        snap();
        send(8'h77);
        repeat (3000) @(negedge clk);
        check("stall_busy", 32'(bus.busy), 32'd1);
        check("stall_sclk", 32'(bus.sclk), 32'd0);
        check("stall_rises", 32'(rise_cnt - r0), 32'd0);
        check("stall_no_done", 32'(done_cnt - d0), 32'd0);
        div_en = 1'b1;
        wait_done("stall_resume_done", 12000);
        repeat (3) @(negedge clk);
        check("stall_resume_rx", 32'(bus.rx_data), 32'h77);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
